vga_pattern_renderer: RTL

// Drawing stage directly upstream of the VGA controller: samples the controller's

---
 rtl/vga_draw_pkg.sv | 47 ++++
 rtl/vga_bounce_axis.sv | 64 ++++++
 rtl/vga_pattern_renderer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/vga_draw_pkg.sv
// Shared definitions for the VGA drawing stage: visible area, pattern modes,
// the {R,G,B} pixel type and the colour-bar palette.
package vga_draw_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int BAR_WIDTH = H_ACTIVE / 8;

  typedef enum logic [1:0] {
    MODE_SOLID    = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_GRADIENT = 2'd3
  } mode_e;

  typedef struct packed {
    logic [9:0] red;
    logic [9:0] green;
    logic [9:0] blue;
  } rgb_t;

  localparam rgb_t COLOR_BLACK   = '{red: 10'h000, green: 10'h000, blue: 10'h000};
  localparam rgb_t COLOR_WHITE   = '{red: 10'h3FF, green: 10'h3FF, blue: 10'h3FF};
  localparam rgb_t COLOR_YELLOW  = '{red: 10'h3FF, green: 10'h3FF, blue: 10'h000};
  localparam rgb_t COLOR_CYAN    = '{red: 10'h000, green: 10'h3FF, blue: 10'h3FF};
  localparam rgb_t COLOR_GREEN   = '{red: 10'h000, green: 10'h3FF, blue: 10'h000};
  localparam rgb_t COLOR_MAGENTA = '{red: 10'h3FF, green: 10'h000, blue: 10'h3FF};
  localparam rgb_t COLOR_RED     = '{red: 10'h3FF, green: 10'h000, blue: 10'h000};
  localparam rgb_t COLOR_BLUE    = '{red: 10'h000, green: 10'h000, blue: 10'h3FF};

  // Classic SMPTE-style bar order, left to right.
  function automatic rgb_t barColor(input logic [2:0] bar);
    rgb_t color;
    case (bar)
      3'd0:    color = COLOR_WHITE;
      3'd1:    color = COLOR_YELLOW;
      3'd2:    color = COLOR_CYAN;
      3'd3:    color = COLOR_GREEN;
      3'd4:    color = COLOR_MAGENTA;
      3'd5:    color = COLOR_RED;
      3'd6:    color = COLOR_BLUE;
      default: color = COLOR_BLACK;
    endcase
    return color;
  endfunction

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing box: position register plus an INC/DEC direction
// FSM that reflects off 0 and MAX_POS once per frame tick.
module vga_bounce_axis
  import vga_draw_pkg::*;
#(
  parameter int MAX_POS   = 576,
  parameter int START_POS = 100
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       tick_i,
  input  logic       pause_i,
  input  logic [3:0] speed_i,
  output logic [9:0] pos_o,
  output logic       dir_o
);

  localparam logic [0:0] INC = 1'b0;
  localparam logic [0:0] DEC = 1'b1;

  logic [9:0]  pos_q, pos_d;
  logic [0:0]  dir_q, dir_d;
  logic [10:0] sum;
  logic [10:0] speedWide;

  // Position arithmetic is done 11 bits wide so pos+speed cannot wrap.
  always_comb begin
    pos_d     = pos_q;
    dir_d     = dir_q;
    speedWide = {7'b0, speed_i};
    sum       = {1'b0, pos_q} + speedWide;
    if (tick_i && !pause_i && (speed_i != 4'd0)) begin
      if (dir_q == INC) begin
        if (sum >= 11'(MAX_POS)) begin
          pos_d = 10'(MAX_POS);
          dir_d = DEC;
        end else begin
          pos_d = sum[9:0];
        end
      end else begin
        if ({1'b0, pos_q} <= speedWide) begin
          pos_d = 10'd0;
          dir_d = INC;
        end else begin
          pos_d = pos_q - {6'b0, speed_i};
        end
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      pos_q <= 10'(START_POS);
      dir_q <= INC;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos_o = pos_q;
  assign dir_o = dir_q;

endmodule

// File: rtl/vga_pattern_renderer.sv
// Pixel colour generator feeding the VGA controller: background pattern with a
// bouncing box overlaid, registered one clock after the incoming coordinate.
module vga_pattern_renderer
  import vga_draw_pkg::*;
#(
  parameter int          BOX_W     = 64,
  parameter int          BOX_H     = 48,
  parameter int          START_X   = 100,
  parameter int          START_Y   = 50,
  parameter logic [29:0] BOX_COLOR = {10'h3FF, 10'h000, 10'h000},
  parameter logic [29:0] BG_COLOR  = {10'h000, 10'h000, 10'h3FF}
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [9:0] iX,
  input  logic [9:0] iY,
  input  logic [1:0] iMode,
  input  logic [3:0] iSpeed,
  input  logic       iPause,
  output logic [9:0] oRed,
  output logic [9:0] oGreen,
  output logic [9:0] oBlue,
  output logic       oFrame_Tick,
  output logic [9:0] oBox_X,
  output logic [9:0] oBox_Y
);

  logic [9:0] prevY_q;
  mode_e      mode_q;
  logic [3:0] speed_q;
  rgb_t       pixel_q, pixel_d;
  logic       frameTick;
  logic [9:0] boxX, boxY;
  logic       dirX, dirY;
  logic       inBox;
  logic       inBlank;
  logic [2:0] bar;

  // Tick fires on the single clock where the line count steps into blanking.
  assign frameTick = (prevY_q == 10'(V_ACTIVE - 1)) && (iY == 10'(V_ACTIVE));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      prevY_q <= 10'd0;
      mode_q  <= MODE_SOLID;
      speed_q <= 4'd0;
    end else begin
      prevY_q <= iY;
      if (frameTick) begin
        mode_q  <= mode_e'(iMode);
        speed_q <= iSpeed;
      end
    end
  end

  vga_bounce_axis #(
    .MAX_POS  (H_ACTIVE - BOX_W),
    .START_POS(START_X)
  ) uAxisX (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .tick_i (frameTick),
    .pause_i(iPause),
    .speed_i(speed_q),
    .pos_o  (boxX),
    .dir_o  (dirX)
  );

  vga_bounce_axis #(
    .MAX_POS  (V_ACTIVE - BOX_H),
    .START_POS(START_Y)
  ) uAxisY (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .tick_i (frameTick),
    .pause_i(iPause),
    .speed_i(speed_q),
    .pos_o  (boxY),
    .dir_o  (dirY)
  );

  // Box test uses the registered box position, which only moves in blanking.
  always_comb begin
    inBlank = (iX >= 10'(H_ACTIVE)) || (iY >= 10'(V_ACTIVE));
    inBox   = ({1'b0, iX} >= {1'b0, boxX}) &&
              ({1'b0, iX} <  ({1'b0, boxX} + 11'(BOX_W))) &&
              ({1'b0, iY} >= {1'b0, boxY}) &&
              ({1'b0, iY} <  ({1'b0, boxY} + 11'(BOX_H)));
    bar     = 3'(iX / 10'(BAR_WIDTH));
    pixel_d = COLOR_BLACK;
    if (inBlank) begin
      pixel_d = COLOR_BLACK;
    end else if (inBox) begin
      pixel_d = rgb_t'(BOX_COLOR);
    end else begin
      case (mode_q)
        MODE_SOLID:   pixel_d = rgb_t'(BG_COLOR);
        MODE_BARS:    pixel_d = barColor(bar);
        MODE_CHECKER: pixel_d = (iX[5] ^ iY[5]) ? COLOR_WHITE : COLOR_BLACK;
        default: begin
          pixel_d.red   = iX;
          pixel_d.green = {iY[8:0], 1'b0};
          pixel_d.blue  = 10'd0;
        end
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      pixel_q <= COLOR_BLACK;
    end else begin
      pixel_q <= pixel_d;
    end
  end

  assign oRed        = pixel_q.red;
  assign oGreen      = pixel_q.green;
  assign oBlue       = pixel_q.blue;
  assign oFrame_Tick = frameTick;
  assign oBox_X      = boxX;
  assign oBox_Y      = boxY;

endmodule
